// File: rtl/data_mem_sized.sv
// Word-organised data memory with byte/half/word access and fixed latency.
// One request in flight; sub-word loads are sign- or zero-extended.
module data_mem_sized #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        ready,
    output logic        done,
    output logic [31:0] rdata,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] CNT_INIT = 2'(LATENCY - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state, state_nxt;
    logic [1:0]  cnt, cnt_nxt;
    logic        enter_resp;

    logic        accept;
    logic        commit;
    logic        in_err;

    logic        we_q;
    logic [1:0]  size_q;
    logic        uns_q;
    logic [31:0] addr_q;

    logic        s_we;
    logic [1:0]  s_size;
    logic        s_uns;
    logic [31:0] s_addr;
    logic        s_err;
    logic [31:0] s_word;
    logic [31:0] s_load;

    logic [3:0]  be;
    logic [31:0] wd_rep;

    logic [31:0] rdata_q;
    logic        err_q;

    logic [31:0] mem [DEPTH_WORDS] = '{1: 32'h0000_0001, default: 32'h0};

    function automatic logic acc_err(logic [1:0] sz, logic [31:0] a);
        logic e;
        e = |a[31:AW+2];
        unique case (1'b1)
            sz == 2'b00: e = e;
            sz == 2'b01: e = e | a[0];
            sz == 2'b10: e = e | (|a[1:0]);
            default:     e = 1'b1;
        endcase
        return e;
    endfunction

    function automatic logic [31:0] fmt_load(
        logic [31:0] w,
        logic [1:0]  sz,
        logic        uns,
        logic [1:0]  lane
    );
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = w[{lane, 3'b000} +: 8];
        h = lane[1] ? w[31:16] : w[15:0];
        unique case (1'b1)
            sz == 2'b00: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            sz == 2'b01: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            default:     r = w;
        endcase
        return r;
    endfunction

    assign ready  = (state != WAIT);
    assign accept = req & ready & ~reset;
    assign in_err = acc_err(size, addr);
    assign commit = accept & we & ~in_err;

    // Acceptance cycle uses live inputs; later cycles use the captured request.
    assign s_we   = accept ? we          : we_q;
    assign s_size = accept ? size        : size_q;
    assign s_uns  = accept ? unsigned_ld : uns_q;
    assign s_addr = accept ? addr        : addr_q;
    assign s_err  = acc_err(s_size, s_addr);
    assign s_word = mem[s_addr[AW+1:2]];
    assign s_load = fmt_load(s_word, s_size, s_uns, s_addr[1:0]);

    // Lane enables and replicated store data for the addressed bytes.
    always_comb begin
        be     = 4'b0000;
        wd_rep = wdata;
        unique case (1'b1)
            size == 2'b00: begin
                be     = 4'b0001 << addr[1:0];
                wd_rep = {4{wdata[7:0]}};
            end
            size == 2'b01: begin
                be     = addr[1] ? 4'b1100 : 4'b0011;
                wd_rep = {2{wdata[15:0]}};
            end
            size == 2'b10: be = 4'b1111;
            default:       be = 4'b0000;
        endcase
    end

    // Next-state and wait-counter logic.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        enter_resp = 1'b0;
        unique case (state)
            IDLE, RESP: begin
                state_nxt = IDLE;
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_nxt  = RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = CNT_INIT;
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 2'd1;
                if (cnt == 2'd1) begin
                    state_nxt  = RESP;
                    enter_resp = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 2'd0;
            end
        endcase
    end

    // State, counter and response registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 2'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            err_q   <= enter_resp & s_err;
            rdata_q <= (enter_resp && !s_err && !s_we) ? s_load : 32'h0;
        end
    end

    // Capture the request fields for multi-cycle accesses.
    always_ff @(posedge clk) begin
        if (reset) begin
            we_q   <= 1'b0;
            size_q <= 2'b00;
            uns_q  <= 1'b0;
            addr_q <= 32'h0;
        end else if (accept) begin
            we_q   <= we;
            size_q <= size;
            uns_q  <= unsigned_ld;
            addr_q <= addr;
        end
    end

    // Byte-lane store commit; contents survive reset.
    always_ff @(posedge clk) begin
        if (commit) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[addr[AW+1:2]][8*b +: 8] <= wd_rep[8*b +: 8];
            end
        end
    end

    assign done  = (state == RESP);
    assign rdata = rdata_q;
    assign err   = err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Directed bench for data_mem_sized at LATENCY=1 and LATENCY=3.
// Expected values are hand-computed from the access sequence.
module tb_data_mem_sized;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic        r1, q1, we1, un1, rdy1, dn1, er1;
    logic [1:0]  sz1;
    logic [31:0] ad1, wd1, rd1;

    logic        r3, q3, we3, un3, rdy3, dn3, er3;
    logic [1:0]  sz3;
    logic [31:0] ad3, wd3, rd3;

    data_mem_sized #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(r1), .req(q1), .we(we1), .size(sz1),
        .unsigned_ld(un1), .addr(ad1), .wdata(wd1),
        .ready(rdy1), .done(dn1), .rdata(rd1), .err(er1)
    );

    data_mem_sized #(.DEPTH_WORDS(256), .LATENCY(3)) dut3 (
        .clk(clk), .reset(r3), .req(q3), .we(we3), .size(sz3),
        .unsigned_ld(un3), .addr(ad3), .wdata(wd3),
        .ready(rdy3), .done(dn3), .rdata(rd3), .err(er3)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive1(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        q1 = 1'b1; we1 = w; sz1 = s; un1 = u; ad1 = a; wd1 = d;
    endtask

    task automatic drive3(input logic w, input logic [1:0] s, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
        q3 = 1'b1; we3 = w; sz3 = s; un3 = u; ad3 = a; wd3 = d;
    endtask

    task automatic test_reset();
        r1 = 1'b1; q1 = 1'b0; we1 = 0; sz1 = 0; un1 = 0; ad1 = 0; wd1 = 0;
        r3 = 1'b1; q3 = 1'b0; we3 = 0; sz3 = 0; un3 = 0; ad3 = 0; wd3 = 0;
        step();
        step();
        r1 = 1'b0;
        r3 = 1'b0;
        total++;
        if ({dn1, er1, rdy1} !== 3'b001 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL reset1: done/err/ready=%b rdata=%h want 001/0",
                     {dn1, er1, rdy1}, rd1);
        end
        total++;
        if ({dn3, er3, rdy3} !== 3'b001 || rd3 !== 32'h0) begin
            bad++;
            $display("FAIL reset3: done/err/ready=%b rdata=%h want 001/0",
                     {dn3, er3, rdy3}, rd3);
        end
    endtask

    task automatic test_init_word1();
        drive1(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        step();
        q1 = 1'b0;
        total++;
        if (dn1 !== 1'b1 || rd1 !== 32'h1 || er1 !== 1'b0) begin
            bad++;
            $display("FAIL init_word1: done=%b rdata=%h err=%b want 1/00000001/0",
                     dn1, rd1, er1);
        end
        step();
        total++;
        if (dn1 !== 1'b0 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL idle_after: done=%b rdata=%h want 0/0", dn1, rd1);
        end
    endtask

    task automatic test_back_to_back();
        drive1(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF);
        step();
        total++;
        if (dn1 !== 1'b1 || er1 !== 1'b0 || rd1 !== 32'h0 || rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_store: done=%b err=%b rdata=%h ready=%b want 1/0/0/1",
                     dn1, er1, rd1, rdy1);
        end
        drive1(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        q1 = 1'b0;
        total++;
        if (dn1 !== 1'b1 || rd1 !== 32'hDEAD_BEEF) begin
            bad++;
            $display("FAIL b2b_load: done=%b rdata=%h want 1/deadbeef", dn1, rd1);
        end
    endtask

    task automatic test_subword();
        logic [31:0] exp [7];
        logic [1:0]  szs [7];
        logic        uns [7];
        logic [31:0] ads [7];
        exp = '{32'hFFFF_FF80, 32'h0000_0080, 32'h80AD_BEEF, 32'hFFFF_80AD,
                32'h0000_BEEF, 32'hFFFF_FFBE, 32'h1234_0000};
        szs = '{2'b00, 2'b00, 2'b10, 2'b01, 2'b01, 2'b00, 2'b10};
        uns = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        ads = '{32'h13, 32'h13, 32'h10, 32'h12, 32'h10, 32'h11, 32'h14};
        drive1(1'b1, 2'b00, 1'b0, 32'h13, 32'hFFFF_FF80);
        step();
        drive1(1'b1, 2'b01, 1'b0, 32'h16, 32'hFFFF_1234);
        step();
        for (int i = 0; i < 7; i++) begin
            drive1(1'b0, szs[i], uns[i], ads[i], 32'h0);
            step();
            total++;
            if (dn1 !== 1'b1 || er1 !== 1'b0 || rd1 !== exp[i]) begin
                bad++;
                $display("FAIL subword[%0d]: done=%b err=%b rdata=%h want 1/0/%h",
                         i, dn1, er1, rd1, exp[i]);
            end
        end
        q1 = 1'b0;
        step();
    endtask

    task automatic test_errors();
        drive1(1'b0, 2'b01, 1'b0, 32'h11, 32'h0);
        step();
        total++;
        if (dn1 !== 1'b1 || er1 !== 1'b1 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL err_half: done=%b err=%b rdata=%h want 1/1/0", dn1, er1, rd1);
        end
        drive1(1'b1, 2'b10, 1'b0, 32'h12, 32'h1111_1111);
        step();
        total++;
        if (dn1 !== 1'b1 || er1 !== 1'b1) begin
            bad++;
            $display("FAIL err_word_st: done=%b err=%b want 1/1", dn1, er1);
        end
        drive1(1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        step();
        total++;
        if (er1 !== 1'b0 || rd1 !== 32'h80AD_BEEF) begin
            bad++;
            $display("FAIL word4_kept: err=%b rdata=%h want 0/80adbeef", er1, rd1);
        end
        drive1(1'b0, 2'b11, 1'b0, 32'h10, 32'h0);
        step();
        total++;
        if (dn1 !== 1'b1 || er1 !== 1'b1 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL err_size: done=%b err=%b rdata=%h want 1/1/0", dn1, er1, rd1);
        end
        drive1(1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        step();
        total++;
        if (er1 !== 1'b1 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL err_range: err=%b rdata=%h want 1/0", er1, rd1);
        end
        drive1(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0);
        step();
        total++;
        if (er1 !== 1'b0 || dn1 !== 1'b1 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL last_word: err=%b done=%b rdata=%h want 0/1/0", er1, dn1, rd1);
        end
        drive1(1'b1, 2'b10, 1'b0, 32'h400, 32'h0000_0077);
        step();
        drive1(1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
        step();
        total++;
        if (er1 !== 1'b0 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL range_st_suppressed: err=%b rdata=%h want 0/0", er1, rd1);
        end
        q1 = 1'b0;
        step();
        total++;
        if (er1 !== 1'b0 || dn1 !== 1'b0) begin
            bad++;
            $display("FAIL err_idle: err=%b done=%b want 0/0", er1, dn1);
        end
    endtask

    task automatic test_reset_overrides_req();
        r1 = 1'b1;
        drive1(1'b1, 2'b10, 1'b0, 32'h30, 32'h0000_0055);
        step();
        r1 = 1'b0;
        total++;
        if (dn1 !== 1'b0 || rdy1 !== 1'b1) begin
            bad++;
            $display("FAIL rst_req: done=%b ready=%b want 0/1", dn1, rdy1);
        end
        drive1(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        step();
        q1 = 1'b0;
        total++;
        if (dn1 !== 1'b1 || rd1 !== 32'h0) begin
            bad++;
            $display("FAIL rst_req_nowrite: done=%b rdata=%h want 1/0", dn1, rd1);
        end
    endtask

    task automatic test_latency3();
        drive3(1'b0, 2'b10, 1'b0, 32'h4, 32'h0);
        step();
        q3 = 1'b0;
        total++;
        if (rdy3 !== 1'b0 || dn3 !== 1'b0) begin
            bad++;
            $display("FAIL lat3_e0: ready=%b done=%b want 0/0", rdy3, dn3);
        end
        step();
        total++;
        if (rdy3 !== 1'b0 || dn3 !== 1'b0) begin
            bad++;
            $display("FAIL lat3_e1: ready=%b done=%b want 0/0", rdy3, dn3);
        end
        step();
        total++;
        if (dn3 !== 1'b1 || rd3 !== 32'h1 || er3 !== 1'b0 || rdy3 !== 1'b1) begin
            bad++;
            $display("FAIL lat3_e2: done=%b rdata=%h err=%b ready=%b want 1/1/0/1",
                     dn3, rd3, er3, rdy3);
        end
        step();
        total++;
        if (dn3 !== 1'b0 || rd3 !== 32'h0) begin
            bad++;
            $display("FAIL lat3_e3: done=%b rdata=%h want 0/0", dn3, rd3);
        end
    endtask

    task automatic test_reset_in_wait();
        drive3(1'b1, 2'b10, 1'b0, 32'h20, 32'hCAFE_F00D);
        step();
        q3 = 1'b0;
        r3 = 1'b1;
        step();
        r3 = 1'b0;
        total++;
        if (dn3 !== 1'b0 || rdy3 !== 1'b1) begin
            bad++;
            $display("FAIL rstwait_a: done=%b ready=%b want 0/1", dn3, rdy3);
        end
        step();
        total++;
        if (dn3 !== 1'b0) begin
            bad++;
            $display("FAIL rstwait_b: done=%b want 0", dn3);
        end
        drive3(1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
        step();
        q3 = 1'b0;
        step();
        step();
        total++;
        if (dn3 !== 1'b1 || rd3 !== 32'hCAFE_F00D || er3 !== 1'b0) begin
            bad++;
            $display("FAIL rstwait_kept: done=%b rdata=%h err=%b want 1/cafef00d/0",
                     dn3, rd3, er3);
        end
        step();
    endtask

    initial begin
        test_reset();
        test_init_word1();
        test_back_to_back();
        test_subword();
        test_errors();
        test_reset_overrides_req();
        test_latency3();
        test_reset_in_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
